// File: rtl/led_chaser_multi.sv
// led_chaser_multi: rotate / bounce / fill LED chaser with prescaler and wrap pulse.
// Ports: clk, reset (async high), enable, mode, dir, period -> q, wrap.
// Define LED_CHASER_PWM_EN to add the bright[3:0] PWM dimming input.
module led_chaser_multi #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] period,
`ifdef LED_CHASER_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL = '1;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             bu_q, bu_d;
  logic             wrap_q, wrap_d;
  logic [1:0]       mode_q, mode_d;
  logic             tick;
  logic             is_rot, is_bnc, is_fil;

  always_comb begin
    tick   = enable && (cnt_q == period);
    is_bnc = (mode_q == 2'b01);
    is_fil = (mode_q == 2'b10);
    is_rot = !is_bnc && !is_fil;
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    bu_d   = bu_q;
    wrap_d = 1'b0;
    mode_d = mode;
    // A mode change restarts the pattern, even while frozen.
    if (mode != mode_q) begin
      cnt_d = '0;
      bu_d  = 1'b1;
      pat_d = (mode == 2'b10) ? '0 : ONE;
    end else if (tick) begin
      cnt_d = '0;
      unique case (1'b1)
        is_rot: begin
          if (!dir) begin
            if (pat_q == MSB) begin
              pat_d  = ONE;
              wrap_d = 1'b1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q == ONE) begin
              pat_d  = MSB;
              wrap_d = 1'b1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        is_bnc: begin
          if (bu_q) begin
            if (pat_q == MSB) begin
              pat_d = pat_q >> 1;
              bu_d  = 1'b0;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q == ONE) begin
              pat_d = pat_q << 1;
              bu_d  = 1'b1;
            end else begin
              pat_d  = pat_q >> 1;
              // Landing back on bit 0 closes one bounce cycle.
              wrap_d = (pat_q == (ONE << 1));
            end
          end
        end
        is_fil: begin
          if (pat_q == ALL) begin
            pat_d  = '0;
            wrap_d = 1'b1;
          end else if (!dir) begin
            pat_d = {pat_q[WIDTH-2:0], 1'b1};
          end else begin
            pat_d = {1'b1, pat_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end else if (enable) begin
      // Wraps modulo 2^DIV_W if period was lowered below cnt.
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      pat_q  <= ONE;
      bu_q   <= 1'b1;
      wrap_q <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      bu_q   <= bu_d;
      wrap_q <= wrap_d;
      mode_q <= mode_d;
    end
  end

  assign wrap = wrap_q;

`ifdef LED_CHASER_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_on_q, pwm_on_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    pwm_on_d  = (pwm_cnt_q < bright);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= 4'd0;
      pwm_on_q  <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_on_q  <= pwm_on_d;
    end
  end

  assign q = pat_q & {WIDTH{pwm_on_q}};
`else
  assign q = pat_q;
`endif

endmodule

// File: tb/tb_led_chaser_multi.sv
// tb_led_chaser_multi: directed vector table plus hand sequences
// for reset, prescaler freeze, mode changes and optional PWM.
module tb_led_chaser_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic        dir;
  logic [23:0] period;
  logic [7:0]  q;
  logic        wrap;
`ifdef LED_CHASER_PWM_EN
  logic [3:0]  bright;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  led_chaser_multi #(.WIDTH(8), .DIV_W(24)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .dir    (dir),
    .period (period),
`ifdef LED_CHASER_PWM_EN
    .bright (bright),
`endif
    .q      (q),
    .wrap   (wrap)
  );

  typedef struct {
    logic       en;
    logic [1:0] md;
    logic       dr;
    logic [7:0] eq;
    logic       ew;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic en, input logic [1:0] md,
                     input logic dr, input logic [7:0] eq,
                     input logic ew);
    vec_t v;
    v.en = en; v.md = md; v.dr = dr; v.eq = eq; v.ew = ew;
    vt.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] eq,
                     input logic ew);
    total++;
    if (q !== eq || wrap !== ew) begin
      bad++;
      $display("FAIL %s: q=%h wrap=%b want q=%h wrap=%b",
               nm, q, wrap, eq, ew);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    mode = 2'b00;
    dir = 1'b0;
    period = '0;
`ifdef LED_CHASER_PWM_EN
    bright = 4'd0;
`endif
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int ones;
    do_reset();
`ifdef LED_CHASER_PWM_EN
    chk("pwm_reset_dark", 8'h00, 1'b0);
    bright = 4'd4;
    repeat (3) step();
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      if (q[0]) ones++;
      step();
    end
    chk_int("pwm_bright4", ones, 8);
    bright = 4'd0;
    repeat (3) step();
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      if (q != 8'h00) ones++;
      step();
    end
    chk_int("pwm_bright0", ones, 0);
`else
    chk("reset_state", 8'h01, 1'b0);

    // Async reset mid-run at q=10.
    enable = 1'b1;
    repeat (4) step();
    chk("run_to_10", 8'h10, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_reset", 8'h01, 1'b0);
    step();
    reset = 1'b0;

    // Prescaler period=3 with an enable freeze.
    do_reset();
    period = 24'd3;
    enable = 1'b1;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (q != 8'h01) begin
        n = i;
        break;
      end
    end
    chk_int("period3_latency", n, 4);
    chk("period3_first", 8'h02, 1'b0);
    repeat (2) step();
    chk("period3_mid", 8'h02, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("freeze", 8'h02, 1'b0);
    end
    enable = 1'b1;
    step();
    chk("resume_hold", 8'h02, 1'b0);
    step();
    chk("resume_step", 8'h04, 1'b0);

    // Table: period=0, one tick every enabled clk.
    add(1, 2'b00, 0, 8'h02, 0);
    add(1, 2'b00, 0, 8'h04, 0);
    add(1, 2'b00, 0, 8'h08, 0);
    add(1, 2'b00, 0, 8'h10, 0);
    add(1, 2'b00, 0, 8'h20, 0);
    add(1, 2'b00, 0, 8'h40, 0);
    add(1, 2'b00, 0, 8'h80, 0);
    add(1, 2'b00, 0, 8'h01, 1);
    add(1, 2'b00, 0, 8'h02, 0);
    add(1, 2'b00, 1, 8'h01, 0);
    add(1, 2'b00, 1, 8'h80, 1);
    add(1, 2'b00, 1, 8'h40, 0);
    add(1, 2'b01, 1, 8'h01, 0);
    add(1, 2'b01, 1, 8'h02, 0);
    add(1, 2'b01, 1, 8'h04, 0);
    add(1, 2'b01, 1, 8'h08, 0);
    add(1, 2'b01, 1, 8'h10, 0);
    add(1, 2'b01, 1, 8'h20, 0);
    add(1, 2'b01, 1, 8'h40, 0);
    add(1, 2'b01, 1, 8'h80, 0);
    add(1, 2'b01, 0, 8'h40, 0);
    add(1, 2'b01, 0, 8'h20, 0);
    add(1, 2'b01, 0, 8'h10, 0);
    add(1, 2'b01, 0, 8'h08, 0);
    add(1, 2'b01, 0, 8'h04, 0);
    add(1, 2'b01, 0, 8'h02, 0);
    add(1, 2'b01, 0, 8'h01, 1);
    add(1, 2'b01, 0, 8'h02, 0);
    add(1, 2'b10, 1, 8'h00, 0);
    add(1, 2'b10, 1, 8'h80, 0);
    add(1, 2'b10, 1, 8'hC0, 0);
    add(1, 2'b10, 1, 8'hE0, 0);
    add(1, 2'b10, 1, 8'hF0, 0);
    add(1, 2'b10, 1, 8'hF8, 0);
    add(1, 2'b10, 1, 8'hFC, 0);
    add(1, 2'b10, 1, 8'hFE, 0);
    add(1, 2'b10, 1, 8'hFF, 0);
    add(1, 2'b10, 1, 8'h00, 1);
    add(1, 2'b10, 1, 8'h80, 0);
    add(1, 2'b10, 0, 8'h01, 0);
    add(1, 2'b10, 0, 8'h03, 0);
    add(1, 2'b00, 0, 8'h01, 0);
    add(0, 2'b11, 0, 8'h01, 0);
    add(0, 2'b11, 0, 8'h01, 0);
    add(1, 2'b11, 0, 8'h02, 0);
    add(0, 2'b11, 0, 8'h02, 0);
    add(0, 2'b10, 0, 8'h00, 0);
    add(0, 2'b10, 0, 8'h00, 0);

    do_reset();
    for (int i = 0; i < vt.size(); i++) begin
      enable = vt[i].en;
      mode = vt[i].md;
      dir = vt[i].dr;
      period = '0;
      step();
      chk($sformatf("vec%0d", i), vt[i].eq, vt[i].ew);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
